// File: rtl/wall_pkg.sv
// Shared constants, colours and FSM state type for the scrolling wall.
package wall_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int WALL_W   = 4;
    localparam int GAP_H    = 20;
    localparam int INIT_GAP = 50;
    localparam int COL_W    = $clog2(WALL_W);

    localparam logic [2:0] WALL_COLOUR = 3'b010;
    localparam logic [2:0] BG_COLOUR   = 3'b000;

    typedef enum logic [1:0] {
        IDLE,
        ERASE,
        MOVE,
        DRAW
    } wall_state_t;

    // The full 8-bit height is compared before truncation so 128..255 still clamp.
    function automatic logic [6:0] clamp_gap(input logic [7:0] h);
        if (h > 8'(SCREEN_H - GAP_H))
            return 7'(SCREEN_H - GAP_H);
        return h[6:0];
    endfunction

endpackage

// File: rtl/wall_col_scanner.sv
// Column-outer / row-inner pixel counter covering one wall footprint, one pixel per cycle.
module wall_col_scanner
    import wall_pkg::*;
(
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    output logic             active,
    output logic [COL_W-1:0] col,
    output logic [6:0]       row,
    output logic             done
);

    assign done = active && (col == COL_W'(WALL_W - 1)) && (row == 7'(SCREEN_H - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            active <= 1'b0;
            col    <= '0;
            row    <= '0;
        end else if (start) begin
            active <= 1'b1;
            col    <= '0;
            row    <= '0;
        end else if (active) begin
            if (row == 7'(SCREEN_H - 1)) begin
                row <= '0;
                if (col == COL_W'(WALL_W - 1)) begin
                    active <= 1'b0;
                    col    <= '0;
                end else begin
                    col <= col + 1'b1;
                end
            end else begin
                row <= row + 1'b1;
            end
        end
    end

endmodule

// File: rtl/wall_scroller.sv
// Scrolls one pipe pair right-to-left one column per frame tick, erasing and redrawing it
// through the VGA adapter, and flags bird/wall overlap.
module wall_scroller
    import wall_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic       enable,
    input  logic       frame_tick,
    input  logic [7:0] height_in,
    output logic       height_req,
    input  logic [7:0] bird_x,
    input  logic [6:0] bird_y,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot,
    output logic       busy,
    output logic [7:0] wall_x,
    output logic [6:0] gap_top,
    output logic       collide
);

    wall_state_t      state;
    logic             pending;
    logic [7:0]       wall_pos;
    logic             go;
    logic             scan_start;
    logic             scan_active;
    logic             scan_done;
    logic [COL_W-1:0] scan_col;
    logic [6:0]       scan_row;
    logic [8:0]       pix_x;
    logic [7:0]       gap_end;
    logic             in_gap;
    logic             plot_now;
    logic [8:0]       wall_end;

    assign wall_x     = wall_pos;
    assign go         = (frame_tick || pending) && enable;
    assign scan_start = ((state == IDLE) && go) || (state == MOVE);

    wall_col_scanner u_scanner (
        .clk    (clk),
        .resetn (resetn),
        .start  (scan_start),
        .active (scan_active),
        .col    (scan_col),
        .row    (scan_row),
        .done   (scan_done)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            pending    <= 1'b0;
            busy       <= 1'b0;
            height_req <= 1'b0;
            wall_pos   <= 8'(SCREEN_W - 1);
            gap_top    <= 7'(INIT_GAP);
        end else begin
            height_req <= 1'b0;
            // Only one extra tick is remembered while a scroll is running.
            if ((state != IDLE) && frame_tick && enable)
                pending <= 1'b1;
            case (state)
                IDLE: begin
                    if (go) begin
                        state   <= ERASE;
                        pending <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                ERASE: begin
                    if (scan_done) begin
                        state      <= MOVE;
                        height_req <= (wall_pos == 8'd0);
                    end
                end
                MOVE: begin
                    state <= DRAW;
                    if (wall_pos == 8'd0) begin
                        wall_pos <= 8'(SCREEN_W - 1);
                        gap_top  <= clamp_gap(height_in);
                    end else begin
                        wall_pos <= wall_pos - 8'd1;
                    end
                end
                DRAW: begin
                    if (scan_done) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign pix_x    = {1'b0, wall_pos} + 9'(scan_col);
    assign gap_end  = {1'b0, gap_top} + 8'(GAP_H);
    assign in_gap   = (scan_row >= gap_top) && ({1'b0, scan_row} < gap_end);
    assign plot_now = scan_active && ((state == ERASE) || (state == DRAW))
                      && (pix_x < 9'(SCREEN_W)) && !in_gap;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vga_plot   <= 1'b0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
        end else begin
            vga_plot <= plot_now;
            if (plot_now) begin
                vga_x      <= pix_x[7:0];
                vga_y      <= scan_row;
                vga_colour <= (state == DRAW) ? WALL_COLOUR : BG_COLOUR;
            end
        end
    end

    assign wall_end = {1'b0, wall_pos} + 9'(WALL_W - 1);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            collide <= 1'b0;
        else
            collide <= ({1'b0, bird_x} >= {1'b0, wall_pos}) && ({1'b0, bird_x} <= wall_end)
                       && ((bird_y < gap_top) || ({1'b0, bird_y} >= gap_end));
    end

endmodule

// File: tb/tb_wall_scroller.sv
// Directed self-checking bench for wall_scroller: scroll passes, wrap/clamp, pending ticks,
// collision boundaries and asynchronous reset during a redraw.
module tb_wall_scroller;

    logic       clk;
    logic       resetn;
    logic       enable;
    logic       frame_tick;
    logic [7:0] height_in;
    logic       height_req;
    logic [7:0] bird_x;
    logic [6:0] bird_y;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;
    logic       busy;
    logic [7:0] wall_x;
    logic [6:0] gap_top;
    logic       collide;

    int checks = 0;
    int errors = 0;

    int passCycles, eraseCount, drawCount, drawInGap, reqCount;
    int drawXmin, drawXmax, drawYmax;

    wall_scroller dut (
        .clk        (clk),
        .resetn     (resetn),
        .enable     (enable),
        .frame_tick (frame_tick),
        .height_in  (height_in),
        .height_req (height_req),
        .bird_x     (bird_x),
        .bird_y     (bird_y),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot),
        .busy       (busy),
        .wall_x     (wall_x),
        .gap_top    (gap_top),
        .collide    (collide)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // One tick, then watch the whole pass; gapLo is the gap the redraw must leave empty.
    task automatic applyStimulus(input int gapLo);
        int n;
        bit finished;
        passCycles = 0; eraseCount = 0; drawCount = 0; drawInGap = 0; reqCount = 0;
        drawXmin = 999; drawXmax = -1; drawYmax = -1;
        n = 0;
        finished = 0;
        @(negedge clk);
        frame_tick = 1'b1;
        while (!finished && n < 1200) begin
            @(posedge clk);
            #1;
            frame_tick = 1'b0;
            n++;
            if (vga_plot) begin
                if (vga_colour == 3'b010) begin
                    drawCount++;
                    if (int'(vga_x) < drawXmin) drawXmin = int'(vga_x);
                    if (int'(vga_x) > drawXmax) drawXmax = int'(vga_x);
                    if (int'(vga_y) > drawYmax) drawYmax = int'(vga_y);
                    if (int'(vga_y) >= gapLo && int'(vga_y) <= gapLo + 19) drawInGap++;
                end else begin
                    eraseCount++;
                end
            end
            if (height_req) reqCount++;
            if (!busy && passCycles == 0) passCycles = n;
            if (passCycles != 0 && n >= passCycles + 2) finished = 1;
        end
    endtask

    initial begin
        int rises, firstFall, secondRise, plotsAfter;
        bit prevBusy;

        resetn = 1'b0; enable = 1'b1; frame_tick = 1'b0; height_in = 8'd0;
        bird_x = 8'd0; bird_y = 7'd0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_wall_x", wall_x, 159);
        checkOutput("rst_gap_top", gap_top, 50);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_plot", vga_plot, 0);
        checkOutput("rst_req", height_req, 0);
        checkOutput("rst_vga_x", vga_x, 0);
        @(negedge clk);
        resetn = 1'b1;

        // Ticks with enable low are ignored.
        @(negedge clk);
        enable = 1'b0; frame_tick = 1'b1;
        @(posedge clk); #1; frame_tick = 1'b0;
        checkOutput("dis_busy0", busy, 0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("dis_busy1", busy, 0);
        enable = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("dis_busy2", busy, 0);

        // First pass from reset: erase clipped column 159, draw 158..159.
        applyStimulus(50);
        checkOutput("p1_latency", passCycles, 962);
        checkOutput("p1_erase", eraseCount, 100);
        checkOutput("p1_draw", drawCount, 200);
        checkOutput("p1_xmin", drawXmin, 158);
        checkOutput("p1_xmax", drawXmax, 159);
        checkOutput("p1_ingap", drawInGap, 0);
        checkOutput("p1_req", reqCount, 0);
        checkOutput("p1_wall_x", wall_x, 158);
        checkOutput("p1_gap", gap_top, 50);

        // Wrap with a new in-range height.
        @(negedge clk); force dut.wall_pos = 8'd0;
        @(negedge clk); release dut.wall_pos;
        height_in = 8'd60;
        applyStimulus(60);
        checkOutput("p2_erase", eraseCount, 400);
        checkOutput("p2_draw", drawCount, 100);
        checkOutput("p2_xmin", drawXmin, 159);
        checkOutput("p2_xmax", drawXmax, 159);
        checkOutput("p2_ingap", drawInGap, 0);
        checkOutput("p2_req", reqCount, 1);
        checkOutput("p2_wall_x", wall_x, 159);
        checkOutput("p2_gap", gap_top, 60);

        // Two ticks 5 cycles apart plus a dropped third: exactly two passes.
        rises = 0; firstFall = -1; secondRise = -1; prevBusy = 1'b0;
        for (int i = 0; i < 2200; i++) begin
            @(negedge clk);
            frame_tick = (i == 0 || i == 5 || i == 100);
            @(posedge clk); #1;
            frame_tick = 1'b0;
            if (busy && !prevBusy) begin
                rises++;
                if (rises == 2) secondRise = i;
            end
            if (!busy && prevBusy && firstFall < 0) firstFall = i;
            prevBusy = busy;
        end
        checkOutput("pend_passes", rises, 2);
        checkOutput("pend_idle_gap", secondRise - firstFall, 1);
        checkOutput("pend_wall_x", wall_x, 157);
        checkOutput("pend_busy", busy, 0);

        // Collision boundaries: wall 157..160, gap 60..79.
        @(negedge clk); bird_x = 8'd158; bird_y = 7'd65;
        @(posedge clk); #1; checkOutput("col_in_gap", collide, 0);
        @(negedge clk); bird_y = 7'd59;
        @(posedge clk); #1; checkOutput("col_above", collide, 1);
        @(negedge clk); bird_y = 7'd80;
        @(posedge clk); #1; checkOutput("col_below", collide, 1);
        @(negedge clk); bird_y = 7'd79;
        @(posedge clk); #1; checkOutput("col_gap_last", collide, 0);
        @(negedge clk); bird_x = 8'd156; bird_y = 7'd0;
        @(posedge clk); #1; checkOutput("col_left_out", collide, 0);
        @(negedge clk); bird_x = 8'd157;
        @(posedge clk); #1; checkOutput("col_left_edge", collide, 1);
        @(negedge clk); bird_x = 8'd160;
        @(posedge clk); #1; checkOutput("col_right_edge", collide, 1);
        @(negedge clk); bird_x = 8'd161;
        @(posedge clk); #1; checkOutput("col_right_out", collide, 0);

        // Wrap with an oversized height: gap clamps to 100.
        @(negedge clk); force dut.wall_pos = 8'd0;
        @(negedge clk); release dut.wall_pos;
        height_in = 8'd110;
        applyStimulus(100);
        checkOutput("p3_erase", eraseCount, 400);
        checkOutput("p3_draw", drawCount, 100);
        checkOutput("p3_ymax", drawYmax, 99);
        checkOutput("p3_ingap", drawInGap, 0);
        checkOutput("p3_req", reqCount, 1);
        checkOutput("p3_gap", gap_top, 100);
        checkOutput("p3_wall_x", wall_x, 159);

        // Reset in the middle of the redraw (column 1, row 41 on the VGA bus).
        height_in = 8'd0; bird_x = 8'd0;
        @(negedge clk);
        frame_tick = 1'b1;
        for (int n = 1; n <= 644; n++) begin
            @(posedge clk); #1;
            frame_tick = 1'b0;
        end
        checkOutput("mid_plot", vga_plot, 1);
        checkOutput("mid_colour", vga_colour, 3'b010);
        checkOutput("mid_x", vga_x, 159);
        checkOutput("mid_y", vga_y, 41);
        resetn = 1'b0;
        #1;
        checkOutput("mr_plot", vga_plot, 0);
        checkOutput("mr_busy", busy, 0);
        checkOutput("mr_wall_x", wall_x, 159);
        checkOutput("mr_gap", gap_top, 50);
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        plotsAfter = 0;
        for (int n = 0; n < 8; n++) begin
            @(posedge clk); #1;
            if (vga_plot) plotsAfter++;
        end
        checkOutput("mr_no_plots", plotsAfter, 0);
        checkOutput("mr_busy_after", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wall_scroller.md
Name: wall_scroller

Overview:
Consumes gap heights from the wall height generator and scrolls one wall (pipe pair) right-to-left across the 160x120 VGA frame, one pixel per frame tick. Each tick it erases the old wall, moves it, and redraws it, emitting pixel writes to the VGA adapter. When the wall wraps, it latches a new gap height from upstream and pulses a request so the generator advances. It also reports a registered bird/wall collision flag to the game FSM.

Parameters:
SCREEN_W, 160, frame width in pixels; x range 0..SCREEN_W-1
SCREEN_H, 120, frame height in pixels; y range 0..SCREEN_H-1
WALL_W, 4, wall width in columns
GAP_H, 20, gap height in rows
INIT_GAP, 50, gap_top value after reset
WALL_COLOUR, 3'b010, colour used to draw the wall
BG_COLOUR, 3'b000, colour used to erase

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
enable  in  1  high = frame ticks are accepted; low = tick input ignored
frame_tick  in  1  one-cycle pulse per frame
height_in  in  8  gap top from the height generator
height_req  out  1  one-cycle pulse; upstream advances to its next height
bird_x  in  8  bird column
bird_y  in  7  bird row
vga_x  out  8  pixel column
vga_y  out  7  pixel row
vga_colour  out  3  pixel colour
vga_plot  out  1  pixel write strobe
busy  out  1  high whenever the FSM is not in IDLE
wall_x  out  8  leftmost wall column
gap_top  out  7  first gap row (clamped)
collide  out  1  registered collision flag

Behaviour:
- Reset (async, resetn=0): state IDLE; wall_x=SCREEN_W-1; gap_top=INIT_GAP; pending=0; height_req, vga_plot, collide, busy=0; vga_x, vga_y, vga_colour=0.
- States: IDLE -> ERASE -> MOVE -> DRAW -> IDLE.
- IDLE: on (frame_tick | pending) & enable, go to ERASE and clear pending.
- ERASE: scan col c=0..WALL_W-1 (outer) and row r=0..SCREEN_H-1 (inner), one pixel per cycle, WALL_W*SCREEN_H cycles.
  - Plot only wall pixels: wall_x+c < SCREEN_W (9-bit sum, clipped) and r outside [gap_top, gap_top+GAP_H-1].
  - Colour = BG_COLOUR.
- MOVE: 1 cycle.
  - If wall_x==0: wall_x<=SCREEN_W-1; gap_top<=min(height_in, SCREEN_H-GAP_H); height_req=1 for exactly this cycle.
  - Otherwise wall_x<=wall_x-1.
- DRAW: same scan and clipping as ERASE, colour = WALL_COLOUR, using the updated wall_x and gap_top. Then return to IDLE.
- VGA outputs are registered: a pixel decided in cycle n appears on vga_* in cycle n+1. vga_plot=0 outside ERASE/DRAW and on clipped or gap pixels.
- Latency: tick to busy falling = 2*WALL_W*SCREEN_H+2 cycles (962 at defaults).
- Tick while busy: sets pending (one deep); extra ticks are dropped. A pending tick starts a new ERASE in the cycle after the return to IDLE.
- enable=0: new ticks are ignored; a scroll in progress completes; a pending tick remains held until enable returns.
- collide: updated every cycle from the registered wall_x and gap_top. Set when bird_x in [wall_x, wall_x+WALL_W-1] and (bird_y < gap_top or bird_y >= gap_top+GAP_H); cleared otherwise.
- height_in wider than 7 bits: compare the full 8 bits against SCREEN_H-GAP_H before truncating.
- Reset mid-scroll: immediate return to the reset state; no further plots.

Decomposition:
- Package wall_pkg: SCREEN_W, SCREEN_H, colour constants, state enum.
- Sub-module wall_col_scanner: the col/row nested counter with a start input and a done pulse, used by both ERASE and DRAW.

Test Plan:
- Reset, then one tick (enable=1) -> ERASE runs at columns 159..162 clipped to 159; MOVE sets wall_x=158; DRAW plots columns 158,159, rows 0..49 and 70..119; busy high for 962 cycles; no height_req.
- Force wall_x=0, height_in=8'd60, tick -> single height_req pulse in MOVE; wall_x=159; gap_top=60; DRAW plots col 159, rows 0..59 and 80..119.
- height_in=8'd110 at wrap -> gap_top clamped to 100; no plots in rows 100..119.
- Two ticks 5 cycles apart, then a third while busy -> exactly two scroll passes; wall_x decremented by 2.
- bird_x=wall_x+1: bird_y=gap_top+5 -> collide=0; bird_y=gap_top-1 -> collide=1; bird_y=gap_top+GAP_H -> collide=1.
- resetn low mid-DRAW -> vga_plot=0 immediately; wall_x=159, gap_top=50; busy=0.
